// File: rtl/dac_serial_tx.sv
// Serial transmitter for a 16-bit SPI-style DAC frame: {Control[3:0], Dato[11:0]},
// MSB first, data changes on SCLK falling edges and is sampled by the slave on
// rising edges. Every output is a register, so downstream pins see glitch-free levels.
module dac_serial_tx #(
  parameter int CLK_DIV = 2  // clk cycles per SCLK half-period, 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  Control,
  input  logic [11:0] Dato,
  output logic        CS,
  output logic        SCLK,
  output logic        data_out,
  output logic        Busy,
  output logic        Listo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  // Bit 15 goes straight onto data_out at the accepting edge, so only the
  // remaining 15 bits need to be held for the rest of the frame.
  logic [14:0] frame_tail;
  logic [3:0]  bit_cnt;   // index of the bit currently on data_out
  logic [7:0]  half_cnt;  // clk cycles elapsed in the current SCLK half-period
  logic        half_end;

  assign half_end = (half_cnt == HALF_LAST);

  // Frame sequencer: accepts a request, paces SCLK, shifts bits out and pulses Listo.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frame_tail <= '0;
      bit_cnt    <= '0;
      half_cnt   <= '0;
      CS         <= 1'b1;
      SCLK       <= 1'b0;
      data_out   <= 1'b0;
      Busy       <= 1'b0;
      Listo      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CS       <= 1'b1;
          SCLK     <= 1'b0;
          data_out <= 1'b0;
          Busy     <= 1'b0;
          Listo    <= 1'b0;
          half_cnt <= '0;
          bit_cnt  <= '0;
          if (start) begin
            // Control/Dato are captured only here; later changes cannot
            // disturb the frame in flight.
            frame_tail <= {Control[2:0], Dato};
            data_out   <= Control[3];
            bit_cnt    <= 4'd15;
            CS         <= 1'b0;
            Busy       <= 1'b1;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          if (half_end) begin
            half_cnt <= '0;
            if (!SCLK) begin
              // Rising toggle: data_out holds so the slave samples a stable bit.
              SCLK <= 1'b1;
            end else if (bit_cnt == 4'd0) begin
              // Falling toggle after the last bit closes the frame.
              SCLK     <= 1'b0;
              CS       <= 1'b1;
              data_out <= 1'b0;
              Listo    <= 1'b1;
              state    <= DONE;
            end else begin
              SCLK     <= 1'b0;
              bit_cnt  <= bit_cnt - 4'd1;
              data_out <= frame_tail[bit_cnt - 4'd1];
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        DONE: begin
          // One-cycle completion beat; start is deliberately ignored here.
          Listo <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Bench for dac_serial_tx: one instance with CLK_DIV=2 and one with CLK_DIV=1.
// A bench-side slave shifts data_out in on every observed SCLK rise; expected
// frame contents and timing come from the frame rules ({Control,Dato}, 16 bits,
// 32*CLK_DIV cycles of CS low) rather than from the RTL structure.
module tb_dac_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start1;
  logic [3:0]  ctl0, ctl1;
  logic [11:0] dat0, dat1;
  logic        cs0, sclk0, dout0, busy0, listo0;
  logic        cs1, sclk1, dout1, busy1, listo1;

  dac_serial_tx #(.CLK_DIV(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .Control(ctl0), .Dato(dat0),
    .CS(cs0), .SCLK(sclk0), .data_out(dout0), .Busy(busy0), .Listo(listo0)
  );

  dac_serial_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .Control(ctl1), .Dato(dat1),
    .CS(cs1), .SCLK(sclk1), .data_out(dout1), .Busy(busy1), .Listo(listo1)
  );

  int errors = 0;
  int checks = 0;

  // Sampled view of the selected instance, taken on the falling clock edge.
  logic cs_s, sclk_s, dout_s, busy_s, listo_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int inst);
    @(negedge clk);
    if (inst == 0) begin
      cs_s = cs0; sclk_s = sclk0; dout_s = dout0; busy_s = busy0; listo_s = listo0;
    end else begin
      cs_s = cs1; sclk_s = sclk1; dout_s = dout1; busy_s = busy1; listo_s = listo1;
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_ctl(input int inst, input logic [3:0] c);
    if (inst == 0) ctl0 = c; else ctl1 = c;
  endtask

  task automatic set_dato(input int inst, input logic [11:0] d);
    if (inst == 0) dat0 = d; else dat1 = d;
  endtask

  // Idle/reset pattern {CS,Busy,SCLK,data_out,Listo} = 1,0,0,0,0 for n cycles.
  task automatic quiet(input int inst, input int n, input string tag);
    set_start(inst, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(inst);
      check(tag, 32'({cs_s, busy_s, sclk_s, dout_s, listo_s}), 32'(5'b10000));
    end
  endtask

  // One complete frame. hold keeps start high afterwards for back-to-back
  // operation; noise toggles start randomly during the frame and forces it
  // high during DONE; chg_at (>0) swaps Dato mid-frame.
  task automatic do_frame(input int inst, input logic [3:0] c, input logic [11:0] d,
                          input bit hold, input bit noise,
                          input int chg_at, input logic [11:0] chg_dat);
    int          div;
    logic [15:0] exp_frame;
    logic [15:0] cap;
    int          rises, low, k, listo_k, listo_n, bad_hold, busy_gap;
    logic        p_sclk, p_dout;
    bit          done;
    div       = (inst == 0) ? 2 : 1;
    exp_frame = {c, d};
    cap = '0; rises = 0; k = 0; listo_k = -1; listo_n = 0; bad_hold = 0; busy_gap = 0;
    done = 1'b0;

    set_ctl(inst, c);
    set_dato(inst, d);
    set_start(inst, 1'b1);
    step(inst);
    k = 1;
    check("accept", 32'({cs_s, busy_s, sclk_s, dout_s, listo_s}),
          32'({1'b0, 1'b1, 1'b0, exp_frame[15], 1'b0}));
    if (!hold && !noise) set_start(inst, 1'b0);
    p_sclk = sclk_s;
    p_dout = dout_s;
    low    = 1;

    while (!done && k < 32 * div + 8) begin
      if (noise) set_start(inst, 1'($urandom_range(0, 1)));
      if (k == chg_at) set_dato(inst, chg_dat);
      step(inst);
      k++;
      if (listo_s) listo_n++;
      if (cs_s == 1'b0) begin
        low++;
        if (!busy_s) busy_gap++;
        if (!p_sclk && sclk_s) begin
          cap = {cap[14:0], dout_s};
          rises++;
        end
        if (dout_s !== p_dout && !(p_sclk && !sclk_s)) bad_hold++;
        p_sclk = sclk_s;
        p_dout = dout_s;
      end else begin
        done    = 1'b1;
        listo_k = k;
      end
    end

    check("frame_ends", 32'(done), 32'(1));
    check("done_state", 32'({cs_s, busy_s, sclk_s, dout_s, listo_s}), 32'(5'b11001));
    check("capture", 32'(cap), 32'(exp_frame));
    check("sclk_rises", 32'(rises), 32'(16));
    check("cs_low_cycles", 32'(low), 32'(32 * div));
    check("listo_delay", 32'(listo_k - 1), 32'(32 * div));
    check("data_hold", 32'(bad_hold), 32'(0));
    check("busy_gap", 32'(busy_gap), 32'(0));

    if (noise) set_start(inst, 1'b1);
    step(inst);
    check("idle_after", 32'({cs_s, busy_s, sclk_s, dout_s, listo_s}), 32'(5'b10000));
    check("listo_pulses", 32'(listo_n), 32'(1));
    set_start(inst, hold ? 1'b1 : 1'b0);
    $display("frame inst=%0d ctl=%h dato=%h captured=%h cs_low=%0d rises=%0d",
             inst, c, d, cap, low, rises);
  endtask

  initial begin
    logic [3:0]  rc;
    logic [11:0] rd;
    int          ri;
    bit          rn;

    // Reset, with start asserted to confirm reset wins.
    rst = 1'b1;
    start0 = 1'b1; start1 = 1'b1;
    ctl0 = '0; ctl1 = '0; dat0 = '0; dat1 = '0;
    repeat (3) @(negedge clk);
    step(0);
    check("reset_inst0", 32'({cs_s, busy_s, sclk_s, dout_s, listo_s}), 32'(5'b10000));
    step(1);
    check("reset_inst1", 32'({cs_s, busy_s, sclk_s, dout_s, listo_s}), 32'(5'b10000));
    start0 = 1'b0; start1 = 1'b0;
    rst = 1'b0;
    quiet(0, 2, "idle_start");

    // Basic frame, CLK_DIV=2.
    do_frame(0, 4'b0000, 12'hA5C, 1'b0, 1'b0, 0, 12'h000);
    quiet(0, 3, "idle_post_a5c");

    // Fastest divider.
    do_frame(1, 4'b0011, 12'hFFF, 1'b0, 1'b0, 0, 12'h000);
    quiet(1, 3, "idle_post_3fff");

    // All-zero code with all mode bits set; data_out must stay 0 in idle.
    quiet(0, 2, "idle_pre_f000");
    do_frame(0, 4'hF, 12'h000, 1'b0, 1'b0, 0, 12'h000);
    quiet(0, 2, "idle_post_f000");

    // start held high, Dato changed mid-frame: back-to-back frames.
    do_frame(0, 4'h0, 12'h123, 1'b1, 1'b0, 10, 12'h456);
    do_frame(0, 4'h0, 12'h456, 1'b0, 1'b0, 0, 12'h000);
    quiet(0, 3, "idle_post_b2b");

    // Spurious start during SHIFT and DONE on both dividers.
    do_frame(0, 4'h6, 12'h9C3, 1'b0, 1'b1, 0, 12'h000);
    quiet(0, 5, "no_extra_frame0");
    do_frame(1, 4'hA, 12'h35E, 1'b0, 1'b1, 0, 12'h000);
    quiet(1, 5, "no_extra_frame1");

    // Abort mid-frame with reset (start also high to test override).
    ctl0 = 4'h5; dat0 = 12'hBEE; start0 = 1'b1;
    step(0);
    start0 = 1'b0;
    check("abort_cs_low", 32'(cs_s), 32'(0));
    repeat (19) step(0);
    check("abort_in_frame", 32'(cs_s), 32'(0));
    rst = 1'b1;
    start0 = 1'b1;
    step(0);
    check("abort_state", 32'({cs_s, busy_s, sclk_s, dout_s, listo_s}), 32'(5'b10000));
    $display("abort inst=0 at frame cycle 20 cs=%b sclk=%b listo=%b", cs_s, sclk_s, listo_s);
    rst = 1'b0;
    quiet(0, 6, "abort_no_listo");
    do_frame(0, 4'h5, 12'hBEE, 1'b0, 1'b0, 0, 12'h000);
    quiet(0, 2, "idle_post_abort");

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      ri = int'($urandom_range(0, 1));
      rc = 4'($urandom);
      rd = 12'($urandom);
      rn = 1'($urandom_range(0, 1));
      do_frame(ri, rc, rd, 1'b0, rn, 0, 12'h000);
      quiet(ri, 2, "idle_post_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
